// File: rtl/display_string_reader.sv
// Streams a NUL-terminated string from data memory to the text renderer, one
// character per valid/ready handshake, and shows the delivered count on a 7-segment display.
module display_string_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0040,
    parameter int          NUM_WORDS = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mostrarLetra,
    output logic [31:0] o_memAddr,
    output logic        o_memRdEn,
    input  logic [31:0] i_memRdata,
    output logic [7:0]  o_charData,
    output logic        o_charValid,
    input  logic        i_charReady,
    output logic        o_busy,
    output logic        o_done,
    output logic [6:0]  o_segments
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

    localparam logic [7:0] LAST_WORD = 8'(NUM_WORDS - 1);

    state_t      r_state;
    logic        r_startPrev;
    logic [7:0]  r_wordIdx;
    logic [1:0]  r_byteIdx;
    logic [3:0]  r_charCount;
    logic [31:0] r_wordReg;

    logic        w_start;
    logic [1:0]  w_nextByteIdx;
    logic [7:0]  w_firstByte;
    logic [7:0]  w_nextByte;
    logic [7:0]  w_nextWordIdx;
    logic [31:0] w_nextWordAddr;

    assign w_start        = i_mostrarLetra & ~r_startPrev;
    assign w_nextByteIdx  = r_byteIdx + 2'd1;
    assign w_firstByte    = i_memRdata[7:0];
    assign w_nextByte     = r_wordReg[{w_nextByteIdx, 3'b000} +: 8];
    assign w_nextWordIdx  = r_wordIdx + 8'd1;
    assign w_nextWordAddr = BASE_ADDR + {22'd0, w_nextWordIdx, 2'b00};

    // Outputs are registered one step ahead: each transition sets what the next state presents.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_startPrev <= 1'b1;
            r_wordIdx   <= 8'd0;
            r_byteIdx   <= 2'd0;
            r_charCount <= 4'd0;
            r_wordReg   <= 32'd0;
            o_memAddr   <= BASE_ADDR;
            o_memRdEn   <= 1'b0;
            o_charData  <= 8'd0;
            o_charValid <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            r_startPrev <= i_mostrarLetra;
            o_done      <= 1'b0;
            o_memRdEn   <= 1'b0;
            o_memAddr   <= BASE_ADDR;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_wordIdx   <= 8'd0;
                        r_byteIdx   <= 2'd0;
                        r_charCount <= 4'd0;
                        o_memRdEn   <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= FETCH;
                    end
                end
                FETCH: r_state <= WAIT;
                WAIT: begin
                    r_wordReg   <= i_memRdata;
                    o_charValid <= (w_firstByte != 8'h00);
                    o_charData  <= w_firstByte;
                    r_state     <= EMIT;
                end
                EMIT: begin
                    if (!o_charValid) begin
                        o_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (i_charReady) begin
                        r_charCount <= r_charCount + 4'd1;
                        if (r_byteIdx != 2'd3) begin
                            r_byteIdx   <= w_nextByteIdx;
                            o_charValid <= (w_nextByte != 8'h00);
                            o_charData  <= w_nextByte;
                        end else if (r_wordIdx < LAST_WORD) begin
                            r_byteIdx   <= 2'd0;
                            r_wordIdx   <= w_nextWordIdx;
                            o_charValid <= 1'b0;
                            o_charData  <= 8'd0;
                            o_memRdEn   <= 1'b1;
                            o_memAddr   <= w_nextWordAddr;
                            r_state     <= FETCH;
                        end else begin
                            o_charValid <= 1'b0;
                            o_charData  <= 8'd0;
                            o_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Active-low hex digit, bit order gfedcba.
    always_comb begin
        o_segments = 7'b1111111;
        case (r_charCount)
            4'h0: o_segments = 7'b1000000;
            4'h1: o_segments = 7'b1111001;
            4'h2: o_segments = 7'b0100100;
            4'h3: o_segments = 7'b0110000;
            4'h4: o_segments = 7'b0011001;
            4'h5: o_segments = 7'b0010010;
            4'h6: o_segments = 7'b0000010;
            4'h7: o_segments = 7'b1111000;
            4'h8: o_segments = 7'b0000000;
            4'h9: o_segments = 7'b0010000;
            4'hA: o_segments = 7'b0001000;
            4'hB: o_segments = 7'b0000011;
            4'hC: o_segments = 7'b1000110;
            4'hD: o_segments = 7'b0100001;
            4'hE: o_segments = 7'b0000110;
            4'hF: o_segments = 7'b0001110;
            default: o_segments = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_display_string_reader.sv
// Scoreboard bench for display_string_reader: expected characters and read addresses
// are queued when a read is started and popped as the DUT produces them.
module tb_display_string_reader;
    localparam logic [31:0] BASE = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        mostrarLetra;
    logic [31:0] memAddr;
    logic        memRdEn;
    logic [31:0] memRdata;
    logic [7:0]  charData;
    logic        charValid;
    logic        charReady;
    logic        busy;
    logic        done;
    logic [6:0]  segments;

    logic [31:0] mem [0:7];
    logic [2:0]  memIdx;
    logic [7:0]  expChars [$];
    logic [31:0] expAddrs [$];

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int readCount   = 0;
    bit          stallFlag = 1'b0;
    logic [7:0]  stallData = 8'd0;

    always #5 clk = ~clk;

    display_string_reader #(
        .BASE_ADDR(BASE),
        .NUM_WORDS(2)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_mostrarLetra(mostrarLetra),
        .o_memAddr(memAddr),
        .o_memRdEn(memRdEn),
        .i_memRdata(memRdata),
        .o_charData(charData),
        .o_charValid(charValid),
        .i_charReady(charReady),
        .o_busy(busy),
        .o_done(done),
        .o_segments(segments)
    );

    // Data memory read port: one cycle of latency after the strobe.
    assign memIdx = 3'((memAddr - BASE) >> 2);
    always @(posedge clk) memRdata <= memRdEn ? mem[memIdx] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Monitor: scoreboard pops, handshake stability and idle-value checks.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            stallFlag = 1'b0;
        end else begin
            if (memRdEn) begin
                readCount++;
                if (expAddrs.size() == 0) checkOutput("extraRead", 32'(memRdEn), 32'd0);
                else checkOutput("readAddr", memAddr, expAddrs.pop_front());
            end else begin
                checkOutput("addrIdle", memAddr, BASE);
            end
            if (!charValid) checkOutput("dataIdle", 32'(charData), 32'd0);
            if (stallFlag) begin
                checkOutput("holdValid", 32'(charValid), 32'd1);
                checkOutput("holdData", 32'(charData), 32'(stallData));
            end
            if (charValid && charReady) begin
                if (expChars.size() == 0) checkOutput("extraChar", 32'(charValid), 32'd0);
                else checkOutput("charData", 32'(charData), 32'(expChars.pop_front()));
            end
            stallFlag = charValid && !charReady;
            stallData = charData;
            if (done) doneCount++;
        end
    end

    task automatic loadMem(input logic [31:0] w0, input logic [31:0] w1);
        mem[0] = w0;
        mem[1] = w1;
    endtask

    task automatic pushHello();
        expChars.push_back(8'h48);
        expChars.push_back(8'h45);
        expChars.push_back(8'h4C);
        expChars.push_back(8'h4C);
        expChars.push_back(8'h4F);
        expAddrs.push_back(BASE);
        expAddrs.push_back(BASE + 32'd4);
    endtask

    // Produces a rising edge on mostrarLetra; the next posedge samples the start.
    task automatic applyStimulus();
        mostrarLetra = 1'b0;
        @(posedge clk); #1;
        mostrarLetra = 1'b1;
    endtask

    // Runs the handshake until done, stalling each character and optionally toggling mostrarLetra.
    task automatic runUntilDone(input int stall, input int wiggles, input int budget, input string tag);
        int holdCnt   = 0;
        int wigLeft   = wiggles;
        int startDone = doneCount;
        int cyc       = 0;
        bit lastValid = 1'b0;
        while (doneCount == startDone && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (lastValid && charReady) holdCnt = 0;
            lastValid = charValid;
            if (charValid && holdCnt < stall) begin
                charReady = 1'b0;
                holdCnt++;
            end else begin
                charReady = 1'b1;
            end
            if (charValid && wigLeft > 0) begin
                mostrarLetra = ~mostrarLetra;
                wigLeft--;
            end
        end
        checkOutput({tag, "_donePulses"}, 32'(doneCount - startDone), 32'd1);
        checkOutput({tag, "_busyAfter"}, 32'(busy), 32'd0);
        checkOutput({tag, "_charsLeft"}, 32'(expChars.size()), 32'd0);
        checkOutput({tag, "_readsLeft"}, 32'(expAddrs.size()), 32'd0);
    endtask

    initial begin
        int reads0;
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        mostrarLetra = 1'b1;
        charReady    = 1'b1;
        reset        = 1'b0;

        // Reset asserted mid-cycle; outputs clear without a clock edge.
        #3 reset = 1'b1;
        #1;
        checkOutput("rst_segments", 32'(segments), 32'b1000000);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(charValid), 32'd0);
        checkOutput("rst_rdEn", 32'(memRdEn), 32'd0);
        checkOutput("rst_addr", memAddr, BASE);
        checkOutput("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 checkOutput("noStartAfterReset", 32'(busy), 32'd0);

        // HELLO with ready held high, plus start-to-first-char latency.
        loadMem(32'h4C4C4548, 32'h0000004F);
        pushHello();
        reads0 = readCount;
        applyStimulus();
        @(posedge clk); #1;
        checkOutput("hello_k1_rdEn", 32'(memRdEn), 32'd1);
        checkOutput("hello_k1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("hello_k2_valid", 32'(charValid), 32'd0);
        @(posedge clk); #1;
        checkOutput("hello_k3_valid", 32'(charValid), 32'd1);
        checkOutput("hello_k3_data", 32'(charData), 32'h48);
        runUntilDone(0, 0, 60, "hello");
        checkOutput("hello_reads", 32'(readCount - reads0), 32'd2);
        checkOutput("hello_segments", 32'(segments), 32'b0010010);

        // Backpressure: three stall cycles per character.
        pushHello();
        applyStimulus();
        runUntilDone(3, 0, 200, "bp");
        checkOutput("bp_segments", 32'(segments), 32'b0010010);

        // Unterminated: two full words, truncated at NUM_WORDS.
        loadMem(32'h41414141, 32'h42424242);
        for (int i = 0; i < 4; i++) expChars.push_back(8'h41);
        for (int i = 0; i < 4; i++) expChars.push_back(8'h42);
        expAddrs.push_back(BASE);
        expAddrs.push_back(BASE + 32'd4);
        reads0 = readCount;
        applyStimulus();
        runUntilDone(0, 0, 60, "unterm");
        checkOutput("unterm_reads", 32'(readCount - reads0), 32'd2);
        checkOutput("unterm_segments", 32'(segments), 32'b0000000);

        // Restart pulses during EMIT are ignored; held-high level after done does not restart.
        loadMem(32'h4C4C4548, 32'h0000004F);
        pushHello();
        reads0 = readCount;
        applyStimulus();
        runUntilDone(0, 4, 60, "restart");
        checkOutput("restart_reads", 32'(readCount - reads0), 32'd2);
        checkOutput("restart_levelHigh", 32'(mostrarLetra), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("restart_heldNoBusy", 32'(busy), 32'd0);
        checkOutput("restart_heldNoReads", 32'(readCount - reads0), 32'd2);

        // Abort with reset during the WAIT of word1, then a clean restart.
        for (int i = 0; i < 4; i++) expChars.push_back(mem[0][i*8 +: 8]);
        expAddrs.push_back(BASE);
        expAddrs.push_back(BASE + 32'd4);
        applyStimulus();
        for (int i = 0; i < 40 && !(memRdEn && memAddr == BASE + 32'd4); i++) begin
            @(posedge clk); #1;
        end
        checkOutput("abort_sawFetch1", memAddr, BASE + 32'd4);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_valid", 32'(charValid), 32'd0);
        checkOutput("abort_rdEn", 32'(memRdEn), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_segments", 32'(segments), 32'b1000000);
        checkOutput("abort_charsLeft", 32'(expChars.size()), 32'd0);
        expChars.delete();
        expAddrs.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        reads0 = readCount;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_noAutoStart", 32'(busy), 32'd0);
        checkOutput("abort_noReads", 32'(readCount - reads0), 32'd0);
        pushHello();
        applyStimulus();
        runUntilDone(0, 0, 60, "again");
        checkOutput("again_segments", 32'(segments), 32'b0010010);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/display_string_reader.md
# display_string_reader

Reads a NUL-terminated ASCII string out of the processor's data memory and streams it, one character per handshake, to the VGA text renderer. It is the read side of the memory area that the ARM core writes through its data port. A reading is triggered when `mostrarLetra` rises. A 7-segment display shows how many characters were delivered.

## Interface
- `BASE_ADDR`, default 32'h0000_0040: byte address of the first string word (word-aligned).
- `NUM_WORDS`, default 8: maximum number of 32-bit words read per string (1..256).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset. Everything clears immediately.
- `mostrarLetra`  in  1  start request, synchronous to `clk`. A 0→1 transition starts a read.
- `memAddr`  out  32  byte address to the data-memory read port.
- `memRdEn`  out  1  read strobe, one cycle per word.
- `memRdata`  in  32  read data, valid exactly one cycle after the `memRdEn` cycle.
- `charData`  out  8  current ASCII character.
- `charValid`  out  1  `charData` is valid.
- `charReady`  in  1  renderer accepts the character.
- `busy`  out  1  a read is in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse when a read completes.
- `segments`  out  7  active-low 7-segment pattern of `charCount`, bit order gfedcba.

## Operation
- **Start detection**
  - A register `startPrev` holds last cycle's `mostrarLetra`; its reset value is 1.
  - Start = `mostrarLetra & ~startPrev`, sampled only while in IDLE. Rising edges in any other state are ignored.
- **FSM states**
  - IDLE: waits for start. On start it clears `wordIdx`, `byteIdx` and `charCount`, then goes to FETCH.
  - FETCH: `memRdEn`=1 and `memAddr` = `BASE_ADDR + 4*wordIdx`. Goes to WAIT.
  - WAIT: `memRdata` is captured into `wordReg` at the end of this cycle. Goes to EMIT.
  - EMIT: the current byte is `wordReg[8*byteIdx +: 8]` (little-endian, byte 0 first).
    - If the byte is 8'h00: go to DONE without presenting it.
    - Otherwise drive `charValid`=1 and `charData`=byte. When `charReady`=1 in that cycle, the transfer completes:
      - `charCount` increments, 4 bits, wrapping from 15 to 0.
      - If `byteIdx` < 3: `byteIdx` increments.
      - If `byteIdx` = 3 and `wordIdx` < `NUM_WORDS-1`: `byteIdx`→0, `wordIdx` increments, go to FETCH.
      - If `byteIdx` = 3 and `wordIdx` = `NUM_WORDS-1`: go to DONE (the string was unterminated and is truncated).
  - DONE: `done`=1 for one cycle, then IDLE.
- **Handshake**
  - `charData` and `charValid` must stay stable until `charReady` is seen.
  - `charValid` never drops without a transfer, except on reset.
  - `charReady` has no effect when `charValid`=0.
- **Outputs when idle or outside their state**
  - `memAddr` = `BASE_ADDR` whenever `memRdEn`=0.
  - `charData` = 0 whenever `charValid`=0.
- **Segment decode**
  - `segments` is combinational from `charCount` and covers hex digits 0–F.
  - Examples: 0 = 7'b1000000, 4 = 7'b0011001, 5 = 7'b0010010, F = 7'b0001110.
- **Reset values**
  - State = IDLE.
  - `memRdEn`=0, `memAddr`=`BASE_ADDR`.
  - `charValid`=0, `charData`=0.
  - `busy`=0, `done`=0.
  - `charCount`=0, so `segments`=7'b1000000.
  - `startPrev`=1.
- **Reset mid-operation**: the read is aborted with no further memory access. After reset is released, a new rising edge is required to start again.

## Timing
- Start edge sampled at rising edge k. FETCH occupies cycle k+1, WAIT cycle k+2, and the first EMIT (`charValid`=1) cycle k+3.
- A transfer completes at the rising edge where `charValid`=`charReady`=1. The next character of the same word is presented in the following cycle.
- Word boundary: the transfer of byte 3 is followed by FETCH and WAIT. That gives 2 cycles without `charValid` before the next word's byte 0 appears.
- With `charReady` held at 1, throughput is 4 characters per 6 cycles.
- A NUL byte costs 1 EMIT cycle. DONE follows in the next cycle, and `busy` falls the cycle after DONE.
- `busy` is registered: it is high from cycle k+1 through the DONE cycle inclusive.

## Test plan
- **Reset**: assert `reset` mid-cycle. Outputs clear immediately: `segments`=7'b1000000, `busy`=0, `charValid`=0.
- **"HELLO"**: memory word0=32'h4C4C4548, word1=32'h0000004F, `charReady`=1.
  - Required: `charData` sequence 48,45,4C,4C,4F.
  - First char 3 cycles after the edge, `memRdEn` pulsed twice at addresses 0x40 and 0x44.
  - `done` pulse, `segments`=7'b0010010.
- **Backpressure**: same memory, `charReady` low for 3 cycles on every character.
  - Required: each `charData` held stable while `charValid`=1 and `charReady`=0; the count ends at 5.
- **Unterminated string**: `NUM_WORDS`=2, memory words 32'h41414141 and 32'h42424242.
  - Required: 8 characters, no third read, `done` pulse, `segments`=7'b0000000 (digit 8).
- **Ignored restart**: pulse `mostrarLetra` 0→1→0→1 during EMIT.
  - Required: the stream is unchanged and no extra read occurs.
  - With `mostrarLetra` held at 1 after `done`, no restart until it goes low and then high again.
- **Abort**: assert `reset` during the WAIT of word1.
  - Required: `charValid` and `memRdEn` drop immediately.
  - A new start reads again from 0x40 with the count cleared.
